// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow valid/ready beats into one wide word with lane strobes and early close on last_i
module stream_upsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic                 last_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic [RATIO-1:0]     strb_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i
);
  localparam int CW = RATIO > 1 ? $clog2(RATIO) : 1;
  typedef enum logic {FILL, HOLD} state_t;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic                acc, pop, done;
  logic [OUT_WIDTH-1:0] nxt_data;
  logic [RATIO-1:0]    nxt_strb;
  assign valid_o = state == HOLD;
  assign ready_o = ~flush_i & (~valid_o | ready_i);
  assign acc     = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign done    = (cnt == CW'(RATIO - 1)) | last_i;
  // a pop in the same cycle restarts the word, so the new beat lands on a clean register (cnt is 0 in HOLD)
  always_comb begin
    nxt_data = pop ? '0 : data_o;
    nxt_strb = pop ? '0 : strb_o;
    for (int k = 0; k < RATIO; k++)
      if (cnt == CW'(k)) begin
        nxt_data[k*IN_WIDTH +: IN_WIDTH] = data_i;
        nxt_strb[k] = 1'b1;
      end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || flush_i || (pop && !acc)) begin
      state  <= FILL;
      cnt    <= '0;
      data_o <= '0;
      strb_o <= '0;
      last_o <= 1'b0;
    end else if (acc) begin
      data_o <= nxt_data;
      strb_o <= nxt_strb;
      last_o <= last_i;
      state  <= done ? HOLD : FILL;
      cnt    <= done ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: vector table, hand sequences and random traffic against a word-grouping scoreboard
module tb_stream_upsizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ni, flush, valid, last, rdy, ready_o, last_o, valid_o;
  logic [7:0] data;
  logic [31:0] data_o;
  logic [3:0] strb_o;
  logic flush1, v1, l1, r1, ro1, lo1, vo1;
  logic [7:0] d1, do1;
  logic [0:0] so1;

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .data_i(data), .last_i(last),
    .valid_i(valid), .ready_o(ready_o), .data_o(data_o), .strb_o(strb_o),
    .last_o(last_o), .valid_o(valid_o), .ready_i(rdy));
  stream_upsizer #(.IN_WIDTH(8), .RATIO(1)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush1), .data_i(d1), .last_i(l1),
    .valid_i(v1), .ready_o(ro1), .data_o(do1), .strb_o(so1),
    .last_o(lo1), .valid_o(vo1), .ready_i(r1));

  int checks = 0, failures = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // reference: accepted beats are grouped into words of 4 or up to a last beat
  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} word_t;
  word_t exp_q[$];
  word_t w;
  logic [31:0] cur_d, last_pop;
  logic [3:0] cur_s, last_pop_s;
  int cur_n, pops;
  logic stall_p;
  logic [36:0] held_p;
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete(); cur_d = 0; cur_s = 0; cur_n = 0; stall_p = 0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", valid_o, 1);
        chk("stall_word", {data_o, strb_o, last_o}, held_p);
      end
      chk("ready_rule", ready_o, !flush && (!valid_o || rdy));
      if (flush) begin
        exp_q.delete(); cur_d = 0; cur_s = 0; cur_n = 0;
      end else begin
        if (valid_o && rdy) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL pop_unexpected actual=word %0h required=no word", data_o);
          end else begin
            w = exp_q.pop_front();
            chk("word_data", data_o, w.d);
            chk("word_strb", strb_o, w.s);
            chk("word_last", last_o, w.l);
          end
          pops++; last_pop = data_o; last_pop_s = strb_o;
        end
        if (valid && ready_o) begin
          cur_d[cur_n*8 +: 8] = data; cur_s[cur_n] = 1'b1; cur_n++;
          if (cur_n == 4 || last) begin
            exp_q.push_back({cur_d, cur_s, last});
            cur_d = 0; cur_s = 0; cur_n = 0;
          end
        end
      end
      stall_p = valid_o && !rdy && !flush;
      held_p = {data_o, strb_o, last_o};
    end
  end

  // RATIO=1 reference: output stream equals input stream
  logic [8:0] q1[$];
  logic [8:0] w1;
  int acc1 = 0;
  always @(negedge clk) begin
    if (!rst_ni) q1.delete();
    else begin
      if (vo1 && r1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL r1_pop_unexpected actual=word %0h required=no word", do1);
        end else begin
          w1 = q1.pop_front();
          chk("r1_data", do1, w1[8:1]);
          chk("r1_last", lo1, w1[0]);
          chk("r1_strb", so1, 1);
        end
      end
      if (v1 && ro1) begin
        q1.push_back({d1, l1});
        acc1++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    bit ok = 0;
    valid = 1; data = d; last = l;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = ready_o;
    end
    chk("send_accept", ok, 1);
    @(posedge clk); #1;
    valid = 0; last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {logic v; logic [7:0] d; logic l; logic ev; logic [31:0] ed; logic [3:0] es; logic el;} vec_t;
  vec_t tv[15];
  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic ev, logic [31:0] ed, logic [3:0] es, logic el);
    vec_t r;
    r = '{v, d, l, ev, ed, es, el};
    return r;
  endfunction

  int p0, cyc;
  initial begin
    tv[0]  = mk(1, 8'h11, 0, 0, 32'h0,        4'h0, 0);
    tv[1]  = mk(1, 8'h22, 0, 0, 32'h11,       4'h1, 0);
    tv[2]  = mk(1, 8'h33, 0, 0, 32'h2211,     4'h3, 0);
    tv[3]  = mk(1, 8'h44, 0, 0, 32'h332211,   4'h7, 0);
    tv[4]  = mk(0, 8'h00, 0, 1, 32'h44332211, 4'hF, 0);
    tv[5]  = mk(1, 8'hAA, 0, 0, 32'h0,        4'h0, 0);
    tv[6]  = mk(1, 8'hBB, 1, 0, 32'hAA,       4'h1, 0);
    tv[7]  = mk(1, 8'hCC, 0, 1, 32'hBBAA,     4'h3, 1);
    tv[8]  = mk(0, 8'h00, 0, 0, 32'hCC,       4'h1, 0);
    tv[9]  = mk(1, 8'hDD, 1, 0, 32'hCC,       4'h1, 0);
    tv[10] = mk(0, 8'h00, 0, 1, 32'hDDCC,     4'h3, 1);
    tv[11] = mk(1, 8'hEE, 1, 0, 32'h0,        4'h0, 0);
    tv[12] = mk(1, 8'hFF, 1, 1, 32'hEE,       4'h1, 1);
    tv[13] = mk(0, 8'h00, 0, 1, 32'hFF,       4'h1, 1);
    tv[14] = mk(0, 8'h00, 0, 0, 32'h0,        4'h0, 0);
    rst_ni = 0; flush = 0; valid = 0; data = 0; last = 0; rdy = 1;
    flush1 = 0; v1 = 0; d1 = 0; l1 = 0; r1 = 1;
    idle(2);
    chk("reset_data", data_o, 0);
    chk("reset_strb", strb_o, 0);
    chk("reset_last", last_o, 0);
    chk("reset_valid", valid_o, 0);
    rst_ni = 1;
    @(negedge clk);
    chk("reset_ready", ready_o, 1);
    idle(1);
    for (int i = 0; i < 15; i++) begin
      valid = tv[i].v; data = tv[i].d; last = tv[i].l;
      @(negedge clk);
      chk($sformatf("t%0d_ready", i), ready_o, 1);
      chk($sformatf("t%0d_valid", i), valid_o, tv[i].ev);
      chk($sformatf("t%0d_data", i), data_o, tv[i].ed);
      chk($sformatf("t%0d_strb", i), strb_o, tv[i].es);
      chk($sformatf("t%0d_last", i), last_o, tv[i].el);
      @(posedge clk); #1;
    end
    valid = 0; last = 0;
    // downstream stall with more beats offered
    p0 = pops; rdy = 0;
    for (int k = 0; k < 4; k++) send(8'h11 + 8'(k), 0);
    fork
      for (int k = 0; k < 8; k++) send(8'h20 + 8'(k), 0);
      begin
        repeat (8) begin
          @(negedge clk);
          chk("stall_ready", ready_o, 0);
          chk("stall_data", data_o, 32'h14131211);
        end
        @(posedge clk); #1;
        rdy = 1;
      end
    join
    idle(3);
    chk("stall_words", pops - p0, 3);
    chk("stall_drain", exp_q.size(), 0);
    // continuous stream
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      valid = 1; data = 8'(i); last = 0;
      @(negedge clk);
      chk("stream_ready", ready_o, 1);
      @(posedge clk); #1;
    end
    valid = 0;
    idle(3);
    chk("stream_words", pops - p0, 16);
    // flush mid-word
    p0 = pops;
    send(8'hA1, 0); send(8'hA2, 0);
    flush = 1;
    @(negedge clk);
    chk("flush_ready", ready_o, 0);
    @(posedge clk); #1;
    flush = 0;
    chk("flush_data", data_o, 0);
    chk("flush_strb", strb_o, 0);
    for (int k = 1; k <= 4; k++) send(8'(k), 0);
    idle(3);
    chk("flush_words", pops - p0, 1);
    chk("flush_word", last_pop, 32'h04030201);
    chk("flush_wstrb", last_pop_s, 4'hF);
    // reset mid-word
    p0 = pops;
    send(8'hB1, 0); send(8'hB2, 0);
    rst_ni = 0;
    idle(1);
    chk("rst_data", data_o, 0);
    chk("rst_strb", strb_o, 0);
    chk("rst_valid", valid_o, 0);
    rst_ni = 1;
    for (int k = 1; k <= 4; k++) send(8'(k), 0);
    idle(3);
    chk("rst_words", pops - p0, 1);
    chk("rst_word", last_pop, 32'h04030201);
    chk("rst_wstrb", last_pop_s, 4'hF);
    // random traffic on both widths
    cyc = 0;
    while ((cyc < 1000 || acc1 < 1000) && cyc < 6000) begin
      valid = $urandom_range(0, 3) != 0; data = 8'($urandom); last = $urandom_range(0, 4) == 0;
      rdy = $urandom_range(0, 2) != 0;
      v1 = $urandom_range(0, 3) != 0; d1 = 8'($urandom); l1 = 1'($urandom);
      r1 = $urandom_range(0, 2) != 0;
      @(posedge clk); #1;
      cyc++;
    end
    valid = 0; last = 0; rdy = 1; v1 = 0; r1 = 1;
    idle(5);
    chk("rand_drain", exp_q.size(), 0);
    chk("r1_drain", q1.size(), 0);
    chk("r1_beats", acc1 >= 1000, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
